// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage control, instruction ROM and IF/ID bundle
interface fetch_stage_if #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 16
) ();
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic [INST_W-1:0] inst_id;
  logic [3:0]        opcode_id;
  logic [ADDR_W-1:0] pc_id;
  logic [ADDR_W-1:0] pc_plus1_id;
  logic              valid_id;

  modport master (
    input  stall, redirect, redirect_pc, imem_rdata,
    output imem_en, imem_addr, inst_id, opcode_id, pc_id, pc_plus1_id, valid_id
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rdata,
    input  imem_en, imem_addr, inst_id, opcode_id, pc_id, pc_plus1_id, valid_id
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, instruction ROM drive and IF/ID register of the 16-bit core
module fetch_stage #(
  parameter int ADDR_W   = 8,
  parameter int INST_W   = 16,
  parameter int RESET_PC = 0
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);
  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc_f;
  logic [ADDR_W-1:0] pc_id_q;
  logic              valid_q;
  logic              fetch;

  // A redirect always fetches, even against a stall, so the wrong path is cut at once.
  assign fetch         = rst_n & (bus.redirect | ~bus.stall);
  assign bus.imem_en   = fetch;
  assign bus.imem_addr = bus.redirect ? bus.redirect_pc : pc_f;

  // The ROM holds its output while disabled, so inst_id needs no register of its own.
  assign bus.inst_id     = bus.imem_rdata;
  assign bus.opcode_id   = bus.imem_rdata[INST_W-1 -: 4];
  assign bus.pc_id       = pc_id_q;
  assign bus.pc_plus1_id = pc_id_q + ADDR_ONE;
  assign bus.valid_id    = valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= BOOT;
      pc_f    <= RESET_ADDR;
      pc_id_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state <= state_next;
      if (fetch) begin
        pc_id_q <= bus.imem_addr;
        pc_f    <= bus.imem_addr + ADDR_ONE;
        valid_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = fetch ? RUN : HOLD;
      RUN:     state_next = fetch ? RUN : HOLD;
      HOLD:    state_next = fetch ? RUN : HOLD;
      default: state_next = BOOT;
    endcase
  end
endmodule
